contador_updown_mod: RTL and testbench
======================================

CONTADOR_UPDOWN_MOD -- requirements
Module: contador_updown_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, value of Q after reset (must be <= 2**WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all flops update on its rising edge.
REQ-004 SHALL have port clr_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; one step per enabled clk edge.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous load request.
REQ-008 SHALL have port ld_val  input  WIDTH  load value.
REQ-009 SHALL have port modulo  input  WIDTH  top of count range; Q spans 0..modulo.
REQ-010 SHALL have port sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-011 SHALL have port ovf_clr  input  1  synchronous clear of ovf.
REQ-012 SHALL have port Q  output  WIDTH  registered count value.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port ovf  output  1  sticky boundary-event flag.

Function
REQ-015 SHALL be fully synchronous: every flop on clk rising edge, no derived or gated clocks.
REQ-016 SHALL apply this priority per edge: load > en step > hold.
REQ-017 On load, Q SHALL take min(ld_val, modulo); load SHALL generate no tc and no ovf.
REQ-018 On en & up with Q < modulo, Q SHALL become Q+1.
REQ-019 On en & up with Q >= modulo: sat=0 -> Q=0 (wrap event); sat=1 -> Q=modulo (block event).
REQ-020 On en & ~up with 0 < Q <= modulo, Q SHALL become Q-1.
REQ-021 On en & ~up with Q=0: sat=0 -> Q=modulo (wrap event); sat=1 -> Q=0 (block event).
REQ-022 On en & ~up with Q > modulo (modulo lowered mid-run), Q SHALL become modulo; no event.
REQ-023 With modulo=0, Q SHALL remain 0, and every enabled step SHALL be a wrap or block event per sat.
REQ-024 tc SHALL be high exactly one cycle, in the cycle after an edge producing a wrap event; never for block events.
REQ-025 ovf SHALL be set by any wrap or block event and held until ovf_clr.
REQ-026 When an event and ovf_clr occur on the same edge, ovf SHALL end set (set wins).
REQ-027 Changes to up, sat or modulo SHALL take effect on the next edge with no pipeline delay; step latency is 1 cycle.
REQ-028 All arithmetic SHALL be WIDTH bits, with no unintended carry out of the MSB.

Reset
REQ-029 clr_n low SHALL asynchronously force Q=RESET_VAL, tc=0 and ovf=0 without waiting for a clk edge.
REQ-030 Release of clr_n SHALL be synchronised internally (2-flop deassertion) so the first step occurs no earlier than the second clk edge after release.
REQ-031 Assertion of clr_n mid-count or mid-tc-pulse SHALL abort the pulse and discard any pending load.

Structure
REQ-032 Shared package contador_pkg SHALL hold the WIDTH default, the RESET_VAL default, and the event-kind enum {EV_NONE, EV_WRAP, EV_BLOCK}.
REQ-033 Sub-module contador_step SHALL be combinational and compute next Q and event kind from Q, up, sat and modulo.
REQ-034 The top SHALL hold the state registers, load mux, tc/ovf flops and reset synchroniser.

Verification
REQ-035 WIDTH=8, modulo=9, sat=0, up=1, en=1 from Q=0 for 12 edges -> Q 1..9,0,1,2; tc high once, one cycle after the 9->0 edge; ovf=1.
REQ-036 load ld_val=2, then up=0, sat=1, en=1 for 4 edges -> Q 1,0,0,0; tc never high; ovf set by the first blocked edge.
REQ-037 modulo=100, load ld_val=200 with en=1 same edge -> Q=100; tc=0; ovf unchanged.
REQ-038 clr_n pulled low between edges at Q=57 with tc high -> Q=0 and tc=0 immediately; no step until the second edge after release.
REQ-039 Wrap edge coincident with ovf_clr=1 -> ovf=1; next edge with ovf_clr=1 and no event -> ovf=0.
REQ-040 Q=30, modulo changed 50->10, then up step -> Q=0 with wrap/tc; down step instead -> Q=10 with no event.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and defaults for the up/down modulo counter.
package contador_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int RESET_VAL_DEF = 0;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_WRAP,
    EV_BLOCK
  } ev_t;

endpackage

// File: rtl/contador_step.sv
// Combinational next-count and boundary-event logic.
module contador_step
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] modulo,
  output logic [WIDTH-1:0] q_nxt,
  output ev_t              ev
);

  always_comb begin
    q_nxt = q;
    ev    = EV_NONE;
    if (up) begin
      if (q < modulo) begin
        q_nxt = q + WIDTH'(1);
      end else if (sat) begin
        q_nxt = modulo;
        ev    = EV_BLOCK;
      end else begin
        q_nxt = '0;
        ev    = EV_WRAP;
      end
    end else begin
      // A lowered modulo pulls the count back in range quietly
      if (q > modulo) begin
        q_nxt = modulo;
      end else if (q == '0) begin
        q_nxt = sat ? '0 : modulo;
        ev    = sat ? EV_BLOCK : EV_WRAP;
      end else begin
        q_nxt = q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/contador_updown_mod.sv
// Up/down modulo counter with load, saturate/wrap, tc pulse and sticky ovf.
module contador_updown_mod
  import contador_pkg::*;
#(
  parameter int             WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] modulo,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  logic [1:0]       rst_sync;
  logic             run;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ld_min;
  ev_t              ev;
  logic             step;

  // Reset release is held off two edges before counting resumes
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run    = rst_sync[1];
  assign ld_min = (ld_val > modulo) ? modulo : ld_val;
  assign step   = run && !load && en;

  contador_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q      (Q),
    .up     (up),
    .sat    (sat),
    .modulo (modulo),
    .q_nxt  (q_nxt),
    .ev     (ev)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      Q  <= RESET_VAL;
      tc <= 1'b0;
    end else begin
      tc <= step && (ev == EV_WRAP);
      if (run && load) Q <= ld_min;
      else if (step)   Q <= q_nxt;
    end
  end

  // Set wins over a coincident clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                        ovf <= 1'b0;
    else if (step && (ev != EV_NONE))  ovf <= 1'b1;
    else if (ovf_clr)                  ovf <= 1'b0;
  end

endmodule

// File: tb/tb_contador_updown_mod.sv
// Directed vector bench for contador_updown_mod.
module tb_contador_updown_mod;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] ld_val;
  logic [7:0] modulo;
  logic       sat;
  logic       ovf_clr;
  logic [7:0] Q;
  logic       tc;
  logic       ovf;

  int tests;
  int fails;

  typedef struct {
    logic       load;
    logic [7:0] ld_val;
    logic       en;
    logic       up;
    logic       sat;
    logic [7:0] modulo;
    logic       ovf_clr;
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  contador_updown_mod dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .ld_val  (ld_val),
    .modulo  (modulo),
    .sat     (sat),
    .ovf_clr (ovf_clr),
    .Q       (Q),
    .tc      (tc),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int eq, input int et,
                         input int eo);
    chk({nm, ".Q"}, int'(Q), eq);
    chk({nm, ".tc"}, int'(tc), et);
    chk({nm, ".ovf"}, int'(ovf), eo);
  endtask

  task automatic add(input logic l, input int lv, input logic e,
                     input logic u, input logic s, input int m,
                     input logic oc, input int eq, input logic et,
                     input logic eo);
    vec_t v;
    v.load = l; v.ld_val = 8'(lv); v.en = e; v.up = u; v.sat = s;
    v.modulo = 8'(m); v.ovf_clr = oc; v.q = 8'(eq); v.tc = et;
    v.ovf = eo;
    vq.push_back(v);
  endtask

  task automatic drive(input logic l, input int lv, input logic e,
                       input logic u, input logic s, input int m,
                       input logic oc);
    load = l; ld_val = 8'(lv); en = e; up = u; sat = s;
    modulo = 8'(m); ovf_clr = oc;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clr_n = 1'b0;
    drive(0, 0, 0, 1, 0, 9, 0);
    #12;
    chk_all("reset", 0, 0, 0);

    @(negedge clk);
    clr_n = 1'b1;
    drive(0, 0, 1, 1, 0, 9, 0);
    @(posedge clk); #1;
    chk("sync_e1.Q", int'(Q), 0);
    @(posedge clk); #1;
    chk("sync_e2.Q", int'(Q), 0);

    // count up, modulo 9, wrap
    for (int i = 1; i <= 12; i++) begin
      if (i <= 9)       add(0, 0, 1, 1, 0, 9, 0, i, 0, 0);
      else if (i == 10) add(0, 0, 1, 1, 0, 9, 0, 0, 1, 1);
      else              add(0, 0, 1, 1, 0, 9, 0, i - 10, 0, 1);
    end
    add(0, 0, 0, 1, 0, 9, 0, 2, 0, 1);
    // wrap coincident with ovf_clr, then clear
    add(1, 9, 0, 1, 0, 9, 0, 9, 0, 1);
    add(0, 0, 1, 1, 0, 9, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 9, 1, 0, 0, 0);
    // saturating down from 2
    add(1, 2, 0, 0, 1, 9, 0, 2, 0, 0);
    add(0, 0, 1, 0, 1, 9, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 9, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 9, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 9, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
    // load clamped, load beats en
    add(1, 200, 1, 1, 0, 100, 0, 100, 0, 0);
    // saturating up block at modulo
    add(0, 0, 1, 1, 1, 100, 0, 100, 0, 1);
    add(0, 0, 0, 1, 1, 100, 1, 100, 0, 0);
    // modulo lowered under the count
    add(1, 30, 0, 1, 0, 50, 0, 30, 0, 0);
    add(0, 0, 1, 1, 0, 10, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 10, 1, 0, 0, 0);
    add(1, 30, 0, 1, 0, 50, 0, 30, 0, 0);
    add(0, 0, 1, 0, 0, 10, 0, 10, 0, 0);
    // modulo zero
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    // down wrap into 57 so tc is high at Q=57
    add(1, 0, 0, 0, 0, 57, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 57, 0, 57, 1, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].load, int'(vq[i].ld_val), vq[i].en, vq[i].up,
            vq[i].sat, int'(vq[i].modulo), vq[i].ovf_clr);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), int'(vq[i].q), int'(vq[i].tc),
              int'(vq[i].ovf));
    end

    // async reset mid-pulse with a pending load
    drive(1, 5, 1, 1, 0, 100, 0);
    #2;
    clr_n = 1'b0;
    #1;
    chk_all("async_clr", 0, 0, 0);
    @(posedge clk); #1;
    chk_all("clr_held", 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    drive(0, 0, 1, 1, 0, 100, 0);
    @(posedge clk); #1;
    chk("rel_e1.Q", int'(Q), 0);
    @(posedge clk); #1;
    chk("rel_e2.Q", int'(Q), 0);
    @(posedge clk); #1;
    chk("rel_e3.Q", int'(Q), 1);
    @(posedge clk); #1;
    chk("rel_e4.Q", int'(Q), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
